// File: rtl/ccd_seq_pkg.sv
// rtl/ccd_seq_pkg.sv - shared types and constants for the CCD readout sequencer
package ccd_seq_pkg;

  localparam int TMR_W         = 16;
  localparam int ROW_W_DEFAULT = 12;
  localparam int COL_W_DEFAULT = 12;

  typedef enum logic [3:0] {
    IDLE,
    PAR_REQ,
    PAR_WAIT,
    SETTLE,
    SER_REQ,
    SER_WAIT,
    SAMPLE,
    ROW_END,
    DONE
  } seq_state_t;

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - loadable down-counter shared by settle delay and handshake timeout
import ccd_seq_pkg::*;

module seq_wait_timer (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk_in) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - TMR_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ccd_readout_sequencer.sv
// rtl/ccd_readout_sequencer.sv - row/column scheduler for the parallel and serial CCD clock generators
import ccd_seq_pkg::*;

module ccd_readout_sequencer #(
  parameter int ROW_W          = ROW_W_DEFAULT,
  parameter int COL_W          = COL_W_DEFAULT,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ROW_W-1:0] num_rows,
  input  logic [COL_W-1:0] num_cols,
  output logic             par_start,
  input  logic             par_done,
  output logic             ser_start,
  input  logic             ser_done,
  output logic             adc_sample,
  output logic             busy,
  output logic             frame_done,
  output logic             error,
  output logic [ROW_W-1:0] row_idx,
  output logic [COL_W-1:0] col_idx
);

  seq_state_t       state;
  logic [ROW_W-1:0] rows_q;
  logic [COL_W-1:0] cols_q;
  logic             abort_act;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic             tmr_expired;

  assign abort_act = abort && (state != IDLE);

  // Timeout is armed in each REQ state; the settle delay is armed by the accepted par_done.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = TMR_W'(TIMEOUT_CYCLES);
    tmr_en       = 1'b0;
    case (state)
      PAR_REQ, SER_REQ: tmr_load = 1'b1;
      PAR_WAIT: begin
        tmr_en = 1'b1;
        if (par_done) begin
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(SETTLE_CYCLES - 1);
        end
      end
      SER_WAIT, SETTLE: tmr_en = 1'b1;
      default: ;
    endcase
  end

  seq_wait_timer u_timer (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .clear    (abort_act),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state      <= IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      par_start  <= 1'b0;
      ser_start  <= 1'b0;
      adc_sample <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      row_idx    <= '0;
      col_idx    <= '0;
    end else begin
      par_start  <= 1'b0;
      ser_start  <= 1'b0;
      adc_sample <= 1'b0;
      frame_done <= 1'b0;
      if (abort_act) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            rows_q  <= num_rows;
            cols_q  <= num_cols;
            error   <= 1'b0;
            row_idx <= '0;
            col_idx <= '0;
            busy    <= 1'b1;
            if (num_rows == '0 || num_cols == '0) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              state     <= PAR_REQ;
              par_start <= 1'b1;
            end
          end
          PAR_REQ: state <= PAR_WAIT;
          PAR_WAIT: begin
            if (par_done) begin
              state <= SETTLE;
            end else if (tmr_expired) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          SETTLE: if (tmr_expired) begin
            state     <= SER_REQ;
            ser_start <= 1'b1;
          end
          SER_REQ: state <= SER_WAIT;
          SER_WAIT: begin
            if (ser_done) begin
              state      <= SAMPLE;
              adc_sample <= 1'b1;
            end else if (tmr_expired) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          SAMPLE: begin
            if (col_idx == cols_q - COL_W'(1)) begin
              state <= ROW_END;
            end else begin
              col_idx   <= col_idx + COL_W'(1);
              state     <= SER_REQ;
              ser_start <= 1'b1;
            end
          end
          ROW_END: begin
            col_idx <= '0;
            if (row_idx == rows_q - ROW_W'(1)) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              row_idx   <= row_idx + ROW_W'(1);
              state     <= PAR_REQ;
              par_start <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ccd_readout_sequencer.sv
// tb/tb_ccd_readout_sequencer.sv - directed self-checking bench for ccd_readout_sequencer
module tb_ccd_readout_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [11:0] num_rows;
  logic [11:0] num_cols;
  logic        par_start;
  logic        par_done = 1'b0;
  logic        ser_start;
  logic        ser_done = 1'b0;
  logic        adc_sample;
  logic        busy;
  logic        frame_done;
  logic        error;
  logic [11:0] row_idx;
  logic [11:0] col_idx;

  int n_checks = 0;
  int n_fail   = 0;

  int n_par = 0, n_ser = 0, n_adc = 0, n_fd = 0, n_busy = 0, lat_err = 0;
  int b_par, b_ser, b_adc, b_fd, b_busy;
  int par_cnt = 0, ser_cnt = 0;
  logic par_en = 1'b1, spur_en = 1'b0, lat_en = 1'b0, ser_prev;
  logic [7:0] idx_log [64];

  ccd_readout_sequencer #(
    .ROW_W(12), .COL_W(12), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .abort(abort),
    .num_rows(num_rows), .num_cols(num_cols),
    .par_start(par_start), .par_done(par_done),
    .ser_start(ser_start), .ser_done(ser_done),
    .adc_sample(adc_sample), .busy(busy), .frame_done(frame_done),
    .error(error), .row_idx(row_idx), .col_idx(col_idx)
  );

  always #5 clk_in = ~clk_in;

  // Generator model: answers each request with a done pulse 5 cycles later and tallies outputs.
  always @(negedge clk_in) begin
    ser_prev = ser_done;
    par_done = 1'b0;
    ser_done = 1'b0;
    if (par_cnt != 0) begin
      par_cnt--;
      if (par_cnt == 0 && par_en) par_done = 1'b1;
      if (spur_en && par_cnt == 3) ser_done = 1'b1;
    end
    if (ser_cnt != 0) begin
      ser_cnt--;
      if (ser_cnt == 0) ser_done = 1'b1;
    end
    if (par_start === 1'b1) begin
      n_par++;
      par_cnt = 5;
    end
    if (ser_start === 1'b1) begin
      idx_log[n_ser % 64] = {row_idx[3:0], col_idx[3:0]};
      n_ser++;
      ser_cnt = 5;
    end
    if (adc_sample === 1'b1) n_adc++;
    if (frame_done === 1'b1) n_fd++;
    if (busy === 1'b1) n_busy++;
    if (lat_en && adc_sample !== ser_prev) lat_err++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      #1;
    end
  endtask

  task automatic snap();
    b_par = n_par; b_ser = n_ser; b_adc = n_adc; b_fd = n_fd; b_busy = n_busy;
  endtask

  task automatic kick(input logic [11:0] rows, input logic [11:0] cols);
    num_rows = rows;
    num_cols = cols;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (n_fd != b_fd) seen = 1'b1;
      else tick();
    end
    check_eq(tag, {63'd0, seen}, 64'd1);
    tick(2);
  endtask

  task automatic check_idx_seq(input string tag, input int cols, input int total);
    logic [7:0] exp;
    for (int i = 0; i < total; i++) begin
      exp = {4'(i / cols), 4'(i % cols)};
      check_eq(tag, {56'd0, idx_log[(b_ser + i) % 64]}, {56'd0, exp});
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_rows = '0; num_cols = '0;
    tick(3);
    check_eq("reset_outputs",
             {39'd0, par_start, ser_start, adc_sample, busy, frame_done, error, row_idx, col_idx},
             64'd0);
    rst_n = 1'b1;
    tick(2);

    // Full 2x3 frame with latency tracking
    snap();
    lat_en = 1'b1;
    kick(12'd2, 12'd3);
    check_eq("start_to_par_start", {63'd0, par_start}, 64'd1);
    check_eq("busy_after_start", {63'd0, busy}, 64'd1);
    wait_frame("frame1_done", 400);
    lat_en = 1'b0;
    check_eq("f1_par", 64'(n_par - b_par), 64'd2);
    check_eq("f1_ser", 64'(n_ser - b_ser), 64'd6);
    check_eq("f1_adc", 64'(n_adc - b_adc), 64'd6);
    check_eq("f1_fd", 64'(n_fd - b_fd), 64'd1);
    check_idx_seq("f1_idx", 3, 6);
    check_eq("f1_adc_latency", 64'(lat_err), 64'd0);
    check_eq("f1_final_idx", {40'd0, row_idx, col_idx}, {40'd0, 12'd1, 12'd0});
    check_eq("f1_idle", {62'd0, busy, error}, 64'd0);

    // Zero rows: straight to DONE
    snap();
    kick(12'd0, 12'd5);
    tick(3);
    check_eq("zero_fd", 64'(n_fd - b_fd), 64'd1);
    check_eq("zero_par", 64'(n_par - b_par), 64'd0);
    check_eq("zero_ser", 64'(n_ser - b_ser), 64'd0);
    check_eq("zero_busy_cycles", 64'(n_busy - b_busy), 64'd1);

    // Parallel generator never answers
    snap();
    par_en = 1'b0;
    kick(12'd1, 12'd1);
    for (int i = 0; i < 60 && busy; i++) tick();
    check_eq("to_error", {63'd0, error}, 64'd1);
    check_eq("to_busy", {63'd0, busy}, 64'd0);
    check_eq("to_no_fd", 64'(n_fd - b_fd), 64'd0);
    check_eq("to_no_ser", 64'(n_ser - b_ser), 64'd0);
    par_en = 1'b1;
    snap();
    kick(12'd1, 12'd1);
    check_eq("to_error_cleared", {63'd0, error}, 64'd0);
    wait_frame("to_rerun_done", 200);
    check_eq("to_rerun_ser", 64'(n_ser - b_ser), 64'd1);

    // Abort during the second SER_WAIT, with a simultaneous start
    snap();
    kick(12'd1, 12'd4);
    for (int i = 0; i < 200 && (n_ser - b_ser) < 2; i++) tick();
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_eq("abort_idle", {63'd0, busy}, 64'd0);
    tick();
    check_eq("abort_start_ignored", {62'd0, busy, par_start}, 64'd0);
    tick(20);
    check_eq("abort_ser", 64'(n_ser - b_ser), 64'd2);
    check_eq("abort_adc", 64'(n_adc - b_adc), 64'd1);
    check_eq("abort_no_fd", 64'(n_fd - b_fd), 64'd0);
    check_eq("abort_error", {63'd0, error}, 64'd0);

    // Spurious ser_done in PAR_WAIT and a start/count change mid-frame
    snap();
    spur_en = 1'b1;
    kick(12'd2, 12'd2);
    tick(3);
    kick(12'd5, 12'd5);
    wait_frame("spur_done", 400);
    spur_en = 1'b0;
    check_eq("spur_par", 64'(n_par - b_par), 64'd2);
    check_eq("spur_ser", 64'(n_ser - b_ser), 64'd4);
    check_eq("spur_adc", 64'(n_adc - b_adc), 64'd4);
    check_eq("spur_fd", 64'(n_fd - b_fd), 64'd1);
    check_eq("spur_final_idx", {40'd0, row_idx, col_idx}, {40'd0, 12'd1, 12'd0});

    // Reset during SETTLE, then a clean frame
    snap();
    kick(12'd2, 12'd2);
    for (int i = 0; i < 50 && n_par == b_par; i++) tick();
    tick(6);
    rst_n = 1'b0;
    tick();
    check_eq("midreset_outputs",
             {39'd0, par_start, ser_start, adc_sample, busy, frame_done, error, row_idx, col_idx},
             64'd0);
    rst_n = 1'b1;
    tick(2);
    check_eq("midreset_no_ser", 64'(n_ser - b_ser), 64'd0);
    snap();
    kick(12'd2, 12'd3);
    wait_frame("post_reset_done", 400);
    check_eq("pr_par", 64'(n_par - b_par), 64'd2);
    check_eq("pr_ser", 64'(n_ser - b_ser), 64'd6);
    check_eq("pr_adc", 64'(n_adc - b_adc), 64'd6);
    check_idx_seq("pr_idx", 3, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
